// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Initiator side of the datapath ALU interface. It accepts one command at a
//   time: an 11-bit LEGv8 opcode plus two operands. It decodes the opcode into
//   the 4-bit ALU control code and drives the external ALU from registers. It
//   holds those inputs for SETTLE cycles, then captures BusW/Zero and returns
//   the result over a valid/ready response handshake.
//
// Parameters
//   n        operand/result width
//   SETTLE   cycles the ALU inputs are held before capture (>= 1)
//
// Ports
//   Clk, Reset           rising-edge clock, asynchronous active-high reset
//   CmdValid/CmdReady    command handshake (CmdReady high only in IDLE)
//   CmdOpcode            LEGv8 opcode bits [31:21]
//   CmdA, CmdB           operands (CmdB is the shift amount for LSL/LSR)
//   AluA, AluB, AluCtrl  registered drive to the external ALU
//   AluW, AluZero        result and zero flag returned by the external ALU
//   RspValid/RspReady    response handshake
//   RspData, RspZero     captured result and locally computed zero flag
//   RspErr               unknown opcode (RspData and RspZero forced to 0)
//   ZeroFault            sticky: the ALU Zero flag disagreed with BusW at a capture

module alu_op_sequencer #(
   parameter int n      = 64,
   parameter int SETTLE = 2
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         CmdValid,
   output logic         CmdReady,
   input  logic [10:0]  CmdOpcode,
   input  logic [n-1:0] CmdA,
   input  logic [n-1:0] CmdB,
   output logic [n-1:0] AluA,
   output logic [n-1:0] AluB,
   output logic [3:0]   AluCtrl,
   input  logic [n-1:0] AluW,
   input  logic         AluZero,
   output logic         RspValid,
   input  logic         RspReady,
   output logic [n-1:0] RspData,
   output logic         RspZero,
   output logic         RspErr,
   output logic         ZeroFault
);

   // A zero-cycle settle window would capture BusW before the ALU has seen its inputs.
   generate
      if (SETTLE < 1) begin : g_bad_settle
         $error("alu_op_sequencer: SETTLE must be >= 1");
      end
   endgenerate

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] COUNT_LOAD = CW'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] settle_count;
   logic [3:0]    op_ctrl;
   logic          op_known;
   logic          w_is_zero;

   // The opcode decoder works on the live command opcode. Its result is used only
   // on the accept edge. CBZ and MOVZ ignore their low opcode bits, so they use
   // don't-care patterns.
   always_comb begin
      op_ctrl  = 4'b0000;
      op_known = 1'b1;
      casez (CmdOpcode)
         11'b10001011000,
         11'b11111000010,
         11'b11111000000: op_ctrl = 4'b0010;
         11'b11001011000: op_ctrl = 4'b0110;
         11'b10001010000: op_ctrl = 4'b0000;
         11'b10101010000: op_ctrl = 4'b0001;
         11'b11010011011: op_ctrl = 4'b0011;
         11'b11010011010: op_ctrl = 4'b0100;
         11'b10110100???,
         11'b110100101??: op_ctrl = 4'b0111;
         default:         op_known = 1'b0;
      endcase
   end

   // The response zero flag comes from BusW itself, so a faulty ALU Zero line can be detected.
   assign w_is_zero = (AluW == '0);

   // CmdReady is a pure decode of the state register, so it rises during reset.
   assign CmdReady = (state == S_IDLE);

   // This is the sequencer. IDLE accepts a command. SETTLE holds the ALU inputs
   // and counts down. DONE presents the response until the consumer takes it.
   // An unknown opcode skips SETTLE and leaves the ALU drive untouched.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= S_IDLE;
         settle_count <= '0;
         AluA         <= '0;
         AluB         <= '0;
         AluCtrl      <= 4'b0000;
         RspValid     <= 1'b0;
         RspData      <= '0;
         RspZero      <= 1'b0;
         RspErr       <= 1'b0;
         ZeroFault    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (CmdValid) begin
                  if (op_known) begin
                     AluA         <= CmdA;
                     AluB         <= CmdB;
                     AluCtrl      <= op_ctrl;
                     settle_count <= COUNT_LOAD;
                     state        <= S_SETTLE;
                  end else begin
                     RspErr   <= 1'b1;
                     RspData  <= '0;
                     RspZero  <= 1'b0;
                     RspValid <= 1'b1;
                     state    <= S_DONE;
                  end
               end
            end
            S_SETTLE: begin
               if (settle_count != '0) begin
                  settle_count <= settle_count - 1'b1;
               end else begin
                  RspData   <= AluW;
                  RspZero   <= w_is_zero;
                  RspErr    <= 1'b0;
                  RspValid  <= 1'b1;
                  ZeroFault <= ZeroFault | (AluZero != w_is_zero);
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (RspReady) begin
                  RspValid <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Directed bench for alu_op_sequencer. Two instances share the command
//   opcode/operand inputs and the reset: one uses SETTLE=2, the other SETTLE=4.
//   Each instance has its own behavioural ALU. The SETTLE=2 ALU can be told
//   to report a wrong Zero flag.

module tb_alu_op_sequencer;

   localparam int N = 64;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LSL  = 11'b11010011011;
   localparam logic [10:0] OP_LSR  = 11'b11010011010;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100101;
   localparam logic [10:0] OP_MOVZ = 11'b11010010110;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [10:0]  cmd_opcode = '0;
   logic [N-1:0] cmd_a = '0;
   logic [N-1:0] cmd_b = '0;
   logic         force_zero_low = 1'b0;

   logic         cmd_valid2 = 1'b0, rsp_ready2 = 1'b1;
   logic         cmd_ready2, rsp_valid2, rsp_zero2, rsp_err2, zero_fault2, alu_zero2;
   logic [N-1:0] alu_a2, alu_b2, alu_w2, rsp_data2;
   logic [3:0]   alu_ctrl2;

   logic         cmd_valid4 = 1'b0, rsp_ready4 = 1'b1;
   logic         cmd_ready4, rsp_valid4, rsp_zero4, rsp_err4, zero_fault4, alu_zero4;
   logic [N-1:0] alu_a4, alu_b4, alu_w4, rsp_data4;
   logic [3:0]   alu_ctrl4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // This is a behavioural ALU that follows the datapath's control encoding.
   function automatic logic [N-1:0] alu_model(input logic [3:0] c, input logic [N-1:0] a,
                                              input logic [N-1:0] b);
      case (c)
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0011: return a << b;
         4'b0100: return a >> b;
         4'b0111: return b;
         default: return '0;
      endcase
   endfunction

   assign alu_w2    = alu_model(alu_ctrl2, alu_a2, alu_b2);
   assign alu_zero2 = force_zero_low ? 1'b0 : (alu_w2 == '0);
   assign alu_w4    = alu_model(alu_ctrl4, alu_a4, alu_b4);
   assign alu_zero4 = (alu_w4 == '0);

   alu_op_sequencer #(.n(N), .SETTLE(2)) dut2 (
      .Clk(clk), .Reset(reset), .CmdValid(cmd_valid2), .CmdReady(cmd_ready2),
      .CmdOpcode(cmd_opcode), .CmdA(cmd_a), .CmdB(cmd_b),
      .AluA(alu_a2), .AluB(alu_b2), .AluCtrl(alu_ctrl2), .AluW(alu_w2), .AluZero(alu_zero2),
      .RspValid(rsp_valid2), .RspReady(rsp_ready2), .RspData(rsp_data2),
      .RspZero(rsp_zero2), .RspErr(rsp_err2), .ZeroFault(zero_fault2)
   );

   alu_op_sequencer #(.n(N), .SETTLE(4)) dut4 (
      .Clk(clk), .Reset(reset), .CmdValid(cmd_valid4), .CmdReady(cmd_ready4),
      .CmdOpcode(cmd_opcode), .CmdA(cmd_a), .CmdB(cmd_b),
      .AluA(alu_a4), .AluB(alu_b4), .AluCtrl(alu_ctrl4), .AluW(alu_w4), .AluZero(alu_zero4),
      .RspValid(rsp_valid4), .RspReady(rsp_ready4), .RspData(rsp_data4),
      .RspZero(rsp_zero4), .RspErr(rsp_err4), .ZeroFault(zero_fault4)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // The task presents a command at a negedge while the DUT is idle. It returns
   // at the negedge after the accept edge, with CmdValid dropped.
   task automatic applyStimulus(input bit to4, input logic [10:0] op,
                                input logic [N-1:0] a, input logic [N-1:0] b);
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      checkOutput("cmd_ready_before_accept", 64'(to4 ? cmd_ready4 : cmd_ready2), 64'(1));
      if (to4) cmd_valid4 = 1'b1;
      else     cmd_valid2 = 1'b1;
      @(negedge clk);
      cmd_valid2 = 1'b0;
      cmd_valid4 = 1'b0;
   endtask

   // The task counts negedges until RspValid is seen, bounded by max_cycles.
   task automatic waitRsp(input bit to4, input int max_cycles, output int lat);
      lat = 0;
      while (((to4 ? rsp_valid4 : rsp_valid2) !== 1'b1) && lat < max_cycles) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // With RspReady high, the next edge retires the response and returns to IDLE.
   task automatic finishRsp(input bit to4);
      @(negedge clk);
      checkOutput("rsp_valid_retired", 64'(to4 ? rsp_valid4 : rsp_valid2), 64'(0));
      checkOutput("cmd_ready_after_rsp", 64'(to4 ? cmd_ready4 : cmd_ready2), 64'(1));
   endtask

   task automatic runOp(input string tag, input bit to4, input logic [10:0] op,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [3:0] exp_ctrl, input logic [N-1:0] exp_data,
                        input logic exp_zero, input int exp_lat);
      int lat;
      applyStimulus(to4, op, a, b);
      checkOutput({tag, "_ctrl"}, 64'(to4 ? alu_ctrl4 : alu_ctrl2), 64'(exp_ctrl));
      waitRsp(to4, exp_lat + 4, lat);
      checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      checkOutput({tag, "_data"}, to4 ? rsp_data4 : rsp_data2, exp_data);
      checkOutput({tag, "_zero"}, 64'(to4 ? rsp_zero4 : rsp_zero2), 64'(exp_zero));
      checkOutput({tag, "_err"}, 64'(to4 ? rsp_err4 : rsp_err2), 64'(0));
      finishRsp(to4);
   endtask

   // A watchdog stops the run if the directed sequence stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      logic [N-1:0] held_data;

      // Check the state while reset is held.
      #1;
      checkOutput("reset_cmd_ready", 64'(cmd_ready2), 64'(1));
      checkOutput("reset_rsp_valid", 64'(rsp_valid2), 64'(0));
      checkOutput("reset_alu_ctrl", 64'(alu_ctrl2), 64'(0));
      checkOutput("reset_alu_a", alu_a2, 64'(0));
      checkOutput("reset_zero_fault", 64'(zero_fault2), 64'(0));
      @(negedge clk);
      reset = 1'b0;

      // Check the basic operations and decode coverage.
      runOp("add", 1'b0, OP_ADD, 64'd5, 64'd7, 4'b0010, 64'd12, 1'b0, 2);
      runOp("sub_zero", 1'b0, OP_SUB, 64'd9, 64'd9, 4'b0110, 64'd0, 1'b1, 2);
      runOp("lsl", 1'b0, OP_LSL, 64'd1, 64'd4, 4'b0011, 64'd16, 1'b0, 2);
      runOp("and", 1'b0, OP_AND, 64'hFF00, 64'h0FF0, 4'b0000, 64'h0F00, 1'b0, 2);
      runOp("lsr", 1'b0, OP_LSR, 64'h100, 64'd4, 4'b0100, 64'h10, 1'b0, 2);
      runOp("ldur", 1'b0, OP_LDUR, 64'd100, 64'd8, 4'b0010, 64'd108, 1'b0, 2);
      runOp("stur", 1'b0, OP_STUR, 64'd40, 64'd2, 4'b0010, 64'd42, 1'b0, 2);
      runOp("movz", 1'b0, OP_MOVZ, 64'd3, 64'h1234, 4'b0111, 64'h1234, 1'b0, 2);
      runOp("cbz", 1'b0, OP_CBZ, 64'd77, 64'd0, 4'b0111, 64'd0, 1'b1, 2);
      checkOutput("no_zero_fault_yet", 64'(zero_fault2), 64'(0));

      // Apply consumer backpressure while a new command waits with CmdValid high.
      rsp_ready2 = 1'b0;
      applyStimulus(1'b0, OP_ADD, 64'd20, 64'd22);
      waitRsp(1'b0, 6, lat);
      checkOutput("bp_latency", 64'(lat), 64'(2));
      held_data = rsp_data2;
      checkOutput("bp_data", held_data, 64'd42);
      cmd_opcode = OP_ORR;
      cmd_a      = 64'hF0;
      cmd_b      = 64'h0F;
      cmd_valid2 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_rsp_valid_held", 64'(rsp_valid2), 64'(1));
         checkOutput("bp_rsp_data_held", rsp_data2, held_data);
         checkOutput("bp_cmd_ready_low", 64'(cmd_ready2), 64'(0));
      end
      rsp_ready2 = 1'b1;
      @(negedge clk);
      checkOutput("bp_release_rsp_valid", 64'(rsp_valid2), 64'(0));
      checkOutput("bp_release_cmd_ready", 64'(cmd_ready2), 64'(1));
      checkOutput("bp_not_yet_accepted", 64'(alu_ctrl2), 64'(4'b0010));
      @(negedge clk);
      cmd_valid2 = 1'b0;
      checkOutput("bp_accepted_ready", 64'(cmd_ready2), 64'(0));
      checkOutput("bp_accepted_ctrl", 64'(alu_ctrl2), 64'(4'b0001));
      waitRsp(1'b0, 6, lat);
      checkOutput("bp_orr_latency", 64'(lat), 64'(2));
      checkOutput("bp_orr_data", rsp_data2, 64'hFF);
      finishRsp(1'b0);

      // An unknown opcode raises the response on the accept edge and leaves the ALU drive alone.
      applyStimulus(1'b0, 11'b00000000000, 64'd123, 64'd456);
      waitRsp(1'b0, 6, lat);
      checkOutput("unk_latency", 64'(lat), 64'(0));
      checkOutput("unk_err", 64'(rsp_err2), 64'(1));
      checkOutput("unk_data", rsp_data2, 64'd0);
      checkOutput("unk_zero", 64'(rsp_zero2), 64'(0));
      checkOutput("unk_alu_a", alu_a2, 64'hF0);
      checkOutput("unk_alu_b", alu_b2, 64'h0F);
      checkOutput("unk_alu_ctrl", 64'(alu_ctrl2), 64'(4'b0001));
      finishRsp(1'b0);

      // Make the ALU report a bad Zero flag; the fault must stick afterwards.
      force_zero_low = 1'b1;
      runOp("fault_sub", 1'b0, OP_SUB, 64'd3, 64'd3, 4'b0110, 64'd0, 1'b1, 2);
      checkOutput("zero_fault_set", 64'(zero_fault2), 64'(1));
      force_zero_low = 1'b0;
      runOp("after_fault_add", 1'b0, OP_ADD, 64'd1, 64'd2, 4'b0010, 64'd3, 1'b0, 2);
      checkOutput("zero_fault_sticky", 64'(zero_fault2), 64'(1));

      // Pulse reset in the middle of SETTLE (SETTLE=2).
      applyStimulus(1'b0, OP_ADD, 64'd2, 64'd3);
      #2 reset = 1'b1;
      #1;
      checkOutput("mid_reset_rsp_valid", 64'(rsp_valid2), 64'(0));
      checkOutput("mid_reset_cmd_ready", 64'(cmd_ready2), 64'(1));
      checkOutput("mid_reset_alu_a", alu_a2, 64'd0);
      checkOutput("mid_reset_zero_fault", 64'(zero_fault2), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("post_reset_no_rsp", 64'(rsp_valid2), 64'(0));
      end
      runOp("post_reset_add", 1'b0, OP_ADD, 64'd4, 64'd5, 4'b0010, 64'd9, 1'b0, 2);

      // Check the SETTLE=4 instance's latency and a mid-SETTLE reset on it.
      runOp("s4_add", 1'b1, OP_ADD, 64'd6, 64'd7, 4'b0010, 64'd13, 1'b0, 4);
      applyStimulus(1'b1, OP_ORR, 64'h3, 64'h4);
      @(negedge clk);
      checkOutput("s4_in_settle", 64'(cmd_ready4), 64'(0));
      #2 reset = 1'b1;
      #1;
      checkOutput("s4_reset_rsp_valid", 64'(rsp_valid4), 64'(0));
      checkOutput("s4_reset_cmd_ready", 64'(cmd_ready4), 64'(1));
      checkOutput("s4_reset_alu_ctrl", 64'(alu_ctrl4), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("s4_post_reset_no_rsp", 64'(rsp_valid4), 64'(0));
      end
      runOp("s4_sub", 1'b1, OP_SUB, 64'd10, 64'd3, 4'b0110, 64'd7, 1'b0, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
